// File: rtl/mac_tx_arb_if.sv
`default_nettype none
// ============================================================================
//  Module      : mac_tx_arb_if
//  Description : Beat-stream bundle between N frame sources, the arbiter and
//                the MAC TX. The slave modport is the arbiter's view; the
//                master modport is the surrounding environment's view.
//  Signals     : req_valid_i/start_i/term_i/cancel_i [N]  per-source beat flags
//                req_data_i [N*DATA_W], req_len_i [N*LEN_W] packed per source
//                req_ready_o [N]                           per-source accept
//                ready_i                                   MAC TX accept
//                valid_o/start_o/term_o/cancel_o           output beat flags
//                data_o [DATA_W], len_o [LEN_W]            output beat payload
//                grant_o [N] one-hot owner, err_o stray-beat drop pulse
//  Revision    : 1.0  initial release
// ============================================================================
interface mac_tx_arb_if #(
   parameter int N      = 2,
   parameter int DATA_W = 16,
   parameter int LEN_W  = $clog2(DATA_W / 8) + 1
);
   logic [N-1:0]        req_valid_i;
   logic [N-1:0]        req_start_i;
   logic [N-1:0]        req_term_i;
   logic [N-1:0]        req_cancel_i;
   logic [N*DATA_W-1:0] req_data_i;
   logic [N*LEN_W-1:0]  req_len_i;
   logic [N-1:0]        req_ready_o;
   logic                ready_i;
   logic                valid_o;
   logic                start_o;
   logic                term_o;
   logic                cancel_o;
   logic [DATA_W-1:0]   data_o;
   logic [LEN_W-1:0]    len_o;
   logic [N-1:0]        grant_o;
   logic                err_o;

   modport slave (
      input  req_valid_i, req_start_i, req_term_i, req_cancel_i,
      input  req_data_i, req_len_i, ready_i,
      output req_ready_o, valid_o, start_o, term_o, cancel_o,
      output data_o, len_o, grant_o, err_o
   );

   modport master (
      output req_valid_i, req_start_i, req_term_i, req_cancel_i,
      output req_data_i, req_len_i, ready_i,
      input  req_ready_o, valid_o, start_o, term_o, cancel_o,
      input  data_o, len_o, grant_o, err_o
   );
endinterface
`default_nettype wire

// File: rtl/mac_tx_arb.sv
`default_nettype none
// ============================================================================
//  Module      : mac_tx_arb
//  Description : Packet-granular round-robin arbiter sharing one MAC TX
//                datapath between N frame sources. A grant is held from the
//                start beat to the term/cancel beat, then IFG_CYC idle cycles
//                are enforced before the next grant. Output is registered.
//  Ports       : clk    clock
//                reset  synchronous active-high reset
//                bus    mac_tx_arb_if.slave (request beats in, MAC beat out,
//                       grant_o, err_o)
//  Options     : MAC_TX_ARB_WDOG_EN - when defined, a stalled granted source
//                is aborted after WDOG_CYC idle cycles with a cancel+term beat.
//  Revision    : 1.0  initial release
// ============================================================================
module mac_tx_arb #(
   parameter int N        = 2,
   parameter int DATA_W   = 16,
   parameter int LEN_W    = $clog2(DATA_W / 8) + 1,
   parameter int IFG_CYC  = 2,
   parameter int WDOG_CYC = 64
) (
   input  logic        clk,
   input  logic        reset,
   mac_tx_arb_if.slave bus
);
   localparam int         c_ptr_w    = $clog2(N);
   localparam logic [3:0] c_gap_last = 4'(IFG_CYC - 1);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_XFER = 2'd1,
      S_GAP  = 2'd2
   } state_t;

   if (N < 2 || N > 8) begin : g_chk_n
      $error("mac_tx_arb: N must be 2..8");
   end
   if (IFG_CYC < 0 || IFG_CYC > 15) begin : g_chk_ifg
      $error("mac_tx_arb: IFG_CYC must be 0..15");
   end
   if (WDOG_CYC < 1) begin : g_chk_wdog
      $error("mac_tx_arb: WDOG_CYC must be positive");
   end

   state_t              r_state;
   logic [c_ptr_w-1:0]  r_ptr;
   logic [c_ptr_w-1:0]  r_gidx;
   logic [N-1:0]        r_grant;
   logic [3:0]          r_gap;
   logic                r_valid, r_start, r_term, r_cancel, r_err;
   logic [DATA_W-1:0]   r_data;
   logic [LEN_W-1:0]    r_len;

   logic                w_adv, w_found, w_acc, w_end, w_abort;
   logic [c_ptr_w-1:0]  w_sel, w_src, w_nxt;
   logic [N-1:0]        w_ready, w_stray;
   logic                w_s_valid, w_s_start, w_s_term, w_s_cancel;
   logic [DATA_W-1:0]   w_s_data;
   logic [LEN_W-1:0]    w_s_len;

   // The output register may load whenever it is empty or being drained.
   assign w_adv = bus.ready_i | ~r_valid;

   // Walk the requesters from the highest offset down so that the candidate
   // closest to the pointer (in wrap order) is the last one written.
   always_comb begin : p_select
      w_found = 1'b0;
      w_sel   = '0;
      for (int i = N - 1; i >= 0; i--) begin
         if (bus.req_valid_i[(int'(r_ptr) + i) % N] &&
             bus.req_start_i[(int'(r_ptr) + i) % N]) begin
            w_found = 1'b1;
            w_sel   = c_ptr_w'((int'(r_ptr) + i) % N);
         end
      end
   end

   // In IDLE the source is the arbitration winner, otherwise the owner.
   assign w_src      = (r_state == S_IDLE) ? w_sel : r_gidx;
   assign w_s_valid  = bus.req_valid_i[w_src];
   assign w_s_start  = bus.req_start_i[w_src];
   assign w_s_term   = bus.req_term_i[w_src];
   assign w_s_cancel = bus.req_cancel_i[w_src];
   assign w_s_data   = bus.req_data_i[int'(w_src) * DATA_W +: DATA_W];
   assign w_s_len    = bus.req_len_i[int'(w_src) * LEN_W +: LEN_W];
   assign w_nxt      = (int'(w_src) == N - 1) ? '0 : w_src + 1'b1;

   // Non-start beats seen while nobody owns the datapath are swallowed so a
   // source that lost its grant (reset, watchdog) cannot wedge the bus.
   always_comb begin : p_ready
      w_ready = '0;
      w_stray = '0;
      case (r_state)
         S_IDLE: begin
            w_stray = bus.req_valid_i & ~bus.req_start_i & {N{w_adv}};
            w_ready = w_stray;
            if (w_found) w_ready[w_sel] = w_adv;
         end
         S_XFER: begin
            if (!w_abort) w_ready[r_gidx] = w_adv;
         end
         default: begin
            w_ready = '0;
         end
      endcase
      if (reset) begin
         w_ready = '0;
         w_stray = '0;
      end
   end

   assign w_acc = w_ready[w_src] & w_s_valid &
                  ((r_state == S_XFER) | ((r_state == S_IDLE) & w_found));
   assign w_end = w_acc & (w_s_term | w_s_cancel);

`ifdef MAC_TX_ARB_WDOG_EN
   localparam int                c_wd_w   = $clog2(WDOG_CYC + 1);
   localparam logic [c_wd_w-1:0] c_wd_lim = c_wd_w'(WDOG_CYC);

   logic [c_wd_w-1:0] r_wd;

   // Counts owner stall cycles; saturates at the limit until the abort
   // beat gets into the output register.
   always_ff @(posedge clk) begin
      if (reset) begin
         r_wd <= '0;
      end else if (r_state != S_XFER || w_acc) begin
         r_wd <= '0;
      end else if (!w_s_valid && r_wd != c_wd_lim) begin
         r_wd <= r_wd + 1'b1;
      end
   end

   assign w_abort = (r_state == S_XFER) && (r_wd == c_wd_lim);
`else
   assign w_abort = 1'b0;
`endif

   always_ff @(posedge clk) begin
      if (reset) begin
         r_state  <= S_IDLE;
         r_ptr    <= '0;
         r_gidx   <= '0;
         r_grant  <= '0;
         r_gap    <= '0;
         r_valid  <= 1'b0;
         r_start  <= 1'b0;
         r_term   <= 1'b0;
         r_cancel <= 1'b0;
         r_err    <= 1'b0;
         r_data   <= '0;
         r_len    <= '0;
      end else begin
         r_err <= |w_stray;

         if (w_adv) begin
            if (w_acc) begin
               r_valid  <= 1'b1;
               r_start  <= w_s_start;
               r_term   <= w_s_term;
               r_cancel <= w_s_cancel;
               r_data   <= w_s_data;
               r_len    <= w_s_len;
            end else if (w_abort) begin
               r_valid  <= 1'b1;
               r_start  <= 1'b0;
               r_term   <= 1'b1;
               r_cancel <= 1'b1;
               r_data   <= '0;
               r_len    <= '0;
            end else begin
               r_valid  <= 1'b0;
            end
         end

         case (r_state)
            S_IDLE: begin
               if (w_found) begin
                  r_gidx <= w_sel;
                  if (!w_end) begin
                     r_state <= S_XFER;
                     r_grant <= N'(1) << w_sel;
                  end
               end
            end
            S_XFER: begin
               r_state <= S_XFER;
            end
            S_GAP: begin
               r_gap <= r_gap + 1'b1;
               if (r_gap == c_gap_last) r_state <= S_IDLE;
            end
            default: begin
               r_state <= S_IDLE;
            end
         endcase

         // Frame end (also covers a single start+term beat taken in IDLE).
         if (w_end || (w_abort && w_adv)) begin
            r_grant <= '0;
            r_ptr   <= w_nxt;
            r_gap   <= '0;
            r_state <= (IFG_CYC == 0) ? S_IDLE : S_GAP;
         end
      end
   end

   assign bus.req_ready_o = w_ready;
   assign bus.valid_o     = r_valid;
   assign bus.start_o     = r_start;
   assign bus.term_o      = r_term;
   assign bus.cancel_o    = r_cancel;
   assign bus.data_o      = r_data;
   assign bus.len_o       = r_len;
   assign bus.grant_o     = r_grant;
   assign bus.err_o       = r_err;

endmodule
`default_nettype wire
